// File: rtl/mspeckey_pkg.sv
// Shared types and constants for the 16-bit inverse SPECKEY sequencer.
package mspeckey_pkg;

    typedef logic [15:0] state16_t;
    typedef logic [7:0]  half8_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Rotation amounts of the inverse round (low half, then high half).
    localparam int ROT_LO = 2;
    localparam int ROT_HI = 1;

    // Rotate an 8-bit half right by n places (0 < n < 8).
    function automatic half8_t ror8(input half8_t v, input int n);
        half8_t r;
        r = half8_t'((v >> n) | (v << (8 - n)));
        return r;
    endfunction

endpackage

// File: rtl/mspeckey_dec_round.sv
// One combinational inverse SPECKEY round, without the round-key XOR.
module mspeckey_dec_round
    import mspeckey_pkg::*;
(
    input  state16_t i_state,
    output state16_t o_state
);

    half8_t w_hi_in;
    half8_t w_lo_in;
    half8_t w_t1;
    half8_t w_lo_out;
    half8_t w_t2;
    half8_t w_hi_out;

    assign w_hi_in  = i_state[15:8];
    assign w_lo_in  = i_state[7:0];

    // The low half is recovered first; the high half depends on it.
    assign w_t1     = w_hi_in ^ w_lo_in;
    assign w_lo_out = ror8(w_t1, ROT_LO);
    assign w_t2     = w_hi_in - w_lo_out;      // wraps mod 256
    assign w_hi_out = ror8(w_t2, ROT_HI);

    assign o_state  = {w_hi_out, w_lo_out};

endmodule

// File: rtl/mspeckey_dec_seq.sv
// Iterative inverse SPECKEY sequencer: accepts a state plus ROUNDS round keys,
// runs one shared round per clock, and hands the result out over valid/ready.
module mspeckey_dec_seq
    import mspeckey_pkg::*;
#(
    parameter int ROUNDS = 3
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            state_in,
    input  logic [16*ROUNDS-1:0]   key_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            state_out,
    output logic                   busy
);

    localparam int CNT_W   = $clog2(ROUNDS + 1);
    localparam int N_SLOTS = 1 << CNT_W;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [16*ROUNDS-1:0]  r_key;
    state16_t              r_work;
    state16_t              r_out;

    state16_t              w_round;
    state16_t              w_next;
    state16_t              w_rk [N_SLOTS];

    // Round-key table indexed directly by the counter. Slots beyond ROUNDS
    // are never selected; they exist so the index width matches the counter.
    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_rk
            if (gi < ROUNDS) begin : g_used
                assign w_rk[gi] = r_key[16*(ROUNDS-1-gi) +: 16];
            end else begin : g_unused
                assign w_rk[gi] = '0;
            end
        end
    endgenerate

    mspeckey_dec_round u_round (
        .i_state (r_work),
        .o_state (w_round)
    );

    assign w_next = w_round ^ w_rk[r_cnt];

    // Outputs are decoded from registered state only; rst gates in_ready so
    // nothing is offered while the block is being held in reset.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign state_out = r_out;

    // Control FSM, round counter and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= '0;
            r_work  <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_RUN;
                        r_work  <= state_in;
                        r_key   <= key_in;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_work <= w_next;
                    if (r_cnt == LAST_CNT) begin
                        // Counter holds at its last value rather than wrapping.
                        r_out   <= w_next;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mspeckey_dec_seq.sv
// Bench for mspeckey_dec_seq: a ROUNDS=3 and a ROUNDS=1 instance, scoreboard
// queues filled by the driver, and a negedge monitor that drains them.
module tb_mspeckey_dec_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv3 = 1'b0;
    logic        iv1 = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] sin = '0;
    logic [47:0] key3 = '0;
    logic [15:0] key1 = '0;

    logic        in_ready3, out_valid3, busy3;
    logic [15:0] state_out3;
    logic        in_ready1, out_valid1, busy1;
    logic [15:0] state_out1;

    typedef struct {
        logic [15:0] data;
        int          acc;
    } exp_t;

    exp_t q3[$];
    exp_t q1[$];
    bit   risen [2];
    int   ncyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   rand_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    mspeckey_dec_seq #(.ROUNDS(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(in_ready3),
        .state_in(sin), .key_in(key3), .out_valid(out_valid3),
        .out_ready(out_ready), .state_out(state_out3), .busy(busy3)
    );

    mspeckey_dec_seq #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1),
        .state_in(sin), .key_in(key1), .out_valid(out_valid1),
        .out_ready(out_ready), .state_out(state_out1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, ncyc);
    endtask

    // Reference: n inverse rounds straight from the arithmetic definition.
    function automatic logic [15:0] ref_dec(input logic [15:0] s, input logic [47:0] k, input int n);
        int v, h, l, t1, t2, lo, hi, rk;
        v = int'(s);
        for (int i = 0; i < n; i++) begin
            h  = (v >> 8) & 255;
            l  = v & 255;
            t1 = h ^ l;
            lo = ((t1 >> 2) | (t1 << 6)) & 255;
            t2 = (h - lo + 256) % 256;
            hi = ((t2 >> 1) | (t2 << 7)) & 255;
            rk = int'((k >> (16 * (n - 1 - i))) & 48'hFFFF);
            v  = ((hi << 8) | lo) ^ rk;
        end
        return 16'(v);
    endfunction

    // Monitor one output channel: data every valid cycle, latency on the rise.
    task automatic mon_step(input int ch);
        logic        v;
        logic [15:0] d;
        int          lat;
        int          qsz;
        exp_t        e;
        v   = (ch == 0) ? out_valid3 : out_valid1;
        d   = (ch == 0) ? state_out3 : state_out1;
        lat = (ch == 0) ? 4 : 2;
        qsz = (ch == 0) ? q3.size() : q1.size();
        if (!v || rst) begin
            risen[ch] = 1'b0;
            return;
        end
        if (qsz == 0) begin
            chk((ch == 0) ? "spurious_out3" : "spurious_out1", 32'(v), 32'd0);
            return;
        end
        e = (ch == 0) ? q3[0] : q1[0];
        chk((ch == 0) ? "data3" : "data1", 32'(d), 32'(e.data));
        if (!risen[ch]) begin
            chk((ch == 0) ? "latency3" : "latency1", 32'(ncyc - e.acc), 32'(lat));
            risen[ch] = 1'b1;
        end
        if (out_ready) begin
            if (ch == 0) void'(q3.pop_front());
            else         void'(q1.pop_front());
            $display("out ch%0d data=%h cycle=%0d", ch, d, ncyc);
        end
    endtask

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) mon_step(ch);
    end

    // Offer one block and wait (bounded) for acceptance; push its expectation.
    task automatic send(input int ch, input logic [15:0] s, input logic [47:0] k, input logic [15:0] expv);
        exp_t e;
        bit   ok;
        ok  = 1'b0;
        sin = s;
        if (ch == 0) begin key3 = k; iv3 = 1'b1; end
        else begin key1 = k[15:0]; iv1 = 1'b1; end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if ((ch == 0) ? in_ready3 : in_ready1) begin
                ok     = 1'b1;
                e.data = expv;
                e.acc  = ncyc;
                if (ch == 0) q3.push_back(e);
                else         q1.push_back(e);
                $display("in  ch%0d state=%h key=%h cycle=%0d", ch, s, k, ncyc);
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        iv3 = 1'b0;
        iv1 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (q3.size() == 0 && q1.size() == 0 && !busy3 && !busy1) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] s, e4;
        logic [47:0] k;
        bit          ok;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready3),  32'd0);
        chk("rst_out_valid", 32'(out_valid3), 32'd0);
        chk("rst_busy",      32'(busy3),      32'd0);
        chk("rst_state_out", 32'(state_out3), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready3), 32'd1);
        @(posedge clk); #1;

        // Single-round known answers.
        send(1, 16'h0100, 48'h0000, 16'hE040);
        wait_idle(20);
        send(1, 16'h0100, 48'h00FF, 16'hE0BF);
        wait_idle(20);

        // All-zero block; a competing in_valid during RUN/DONE must be ignored.
        send(0, 16'h0000, 48'h0, 16'h0000);
        sin = 16'hDEAD; key3 = 48'h123456789ABC; iv3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_in_ready", 32'(in_ready3), 32'd0);
            chk("busy_flag",     32'(busy3),     32'd1);
            @(posedge clk); #1;
        end
        iv3 = 1'b0;
        wait_idle(20);

        // Back-pressure: result held stable while out_ready is low.
        out_ready = 1'b0;
        s  = 16'($urandom); k = {16'($urandom), 16'($urandom), 16'($urandom)};
        e4 = ref_dec(s, k, 3);
        send(0, s, k, e4);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid3) ok = 1'b1;
        end
        if (!ok) chk("stall_valid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(out_valid3), 32'd1);
            chk("stall_data",  32'(state_out3), 32'(e4));
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("after_hs_in_ready",  32'(in_ready3),  32'd1);
        chk("after_hs_out_valid", 32'(out_valid3), 32'd0);
        @(posedge clk); #1;

        // Reset in the second RUN cycle discards the block.
        s = 16'h5A5A; k = 48'h0123_4567_89AB;
        send(0, s, k, ref_dec(s, k, 3));
        @(posedge clk); #1;
        rst = 1'b1;
        void'(q3.pop_back());
        @(negedge clk);
        chk("midrun_rst_in_ready", 32'(in_ready3), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_abort_out_valid", 32'(out_valid3), 32'd0);
            chk("post_abort_busy",      32'(busy3),      32'd0);
            chk("post_abort_state_out", 32'(state_out3), 32'd0);
        end
        @(posedge clk); #1;
        s = 16'hBEEF; k = 48'hFEDC_BA98_7654;
        send(0, s, k, ref_dec(s, k, 3));
        wait_idle(20);

        // Random back-to-back blocks with random consumer stalls.
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    s = 16'($urandom);
                    k = {16'($urandom), 16'($urandom), 16'($urandom)};
                    send(0, s, k, ref_dec(s, k, 3));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_idle(100);
        chk("lost_blocks3", 32'(q3.size()), 32'd0);
        chk("lost_blocks1", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
